// File: rtl/ds_pdm_dac.sv
// ds_pdm_dac: first-order delta-sigma modulator turning parallel codes into a
// 1-bit pulse-density stream, with a one-entry valid/ready input buffer whose
// contents are applied only on oversampling-frame boundaries.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          modulator enable; low freezes os_cnt, acc, active and pdm_out
//   din          unsigned code, ones density = din / 2^DATA_W
//   din_valid    din holds a code
//   din_ready    pending buffer empty (registered)
//   pdm_out      registered density stream
//   sample_tick  one-cycle pulse on each frame boundary
//   underrun     one-cycle pulse when a boundary finds no pending code
module ds_pdm_dac #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OSR_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              pdm_out,
    output logic              sample_tick,
    output logic              underrun
);

    localparam int unsigned          SUM_W    = DATA_W + 1;
    localparam logic [OSR_LOG2-1:0]  OS_LAST  = {OSR_LOG2{1'b1}};
    localparam logic [DATA_W-1:0]    MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    logic [OSR_LOG2-1:0] r_os_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_active;
    logic [DATA_W-1:0]   r_pending;
    logic                r_pend_full;

    logic                w_xfer;
    logic                w_boundary;
    logic [SUM_W-1:0]    w_sum;

    assign w_xfer     = din_valid && din_ready;
    assign w_boundary = ena && (r_os_cnt == OS_LAST);
    // Carry out of the accumulator is the density bit.
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(r_active);

    // Input buffer. A transfer needs din_ready, i.e. an empty buffer, so it can
    // never coincide with the boundary draining a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            din_ready   <= 1'b1;
        end else if (w_xfer) begin
            r_pending   <= din;
            r_pend_full <= 1'b1;
            din_ready   <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_pend_full <= 1'b0;
            din_ready   <= 1'b1;
        end
    end

    // Modulator and frame sequencing. The boundary edge still accumulates the
    // outgoing code; the new code is first accumulated on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt    <= '0;
            r_acc       <= '0;
            r_active    <= MIDSCALE;
            pdm_out     <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            if (ena) begin
                r_acc    <= w_sum[DATA_W-1:0];
                pdm_out  <= w_sum[DATA_W];
                r_os_cnt <= r_os_cnt + 1'b1;
                if (w_boundary) begin
                    sample_tick <= 1'b1;
                    if (r_pend_full) begin
                        r_active <= r_pending;
                    end else begin
                        underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ds_pdm_dac.sv
// Directed bench for ds_pdm_dac. Expected per-frame ones counts and underrun
// flags are queued as codes are loaded; a monitor pops one entry per
// sample_tick and compares the completed frame.
module tb_ds_pdm_dac;

    localparam int unsigned DATA_W = 8;
    localparam int          FRAME  = 256;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              pdm_out;
    logic              sample_tick;
    logic              underrun;

    typedef struct {
        int ones;
        int urun;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   pos      = 0;   // enabled edges since reset release
    int   mon_ones = 0;
    int   mon_len  = 0;

    ds_pdm_dac #(.DATA_W(8), .OSR_LOG2(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .pdm_out     (pdm_out),
        .sample_tick (sample_tick),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ones, input int urun);
        exp_t e;
        e.ones = ones;
        e.urun = urun;
        sb.push_back(e);
    endtask

    // Advance n clocks; inputs change at posedge+2, the monitor samples at +1.
    task automatic step(input int n);
        bit counted;
        for (int i = 0; i < n; i++) begin
            counted = (rst_n === 1'b1) && (ena === 1'b1);
            @(posedge clk);
            #2;
            if (counted) pos++;
        end
    endtask

    task automatic to_pos(input int target);
        int guard;
        guard = 0;
        while (pos < target && guard < 4000) begin
            step(1);
            guard++;
        end
        if (pos != target) chk("to_pos_timeout", 32'(pos), 32'(target));
    endtask

    // Present a code and hold din_valid until it is taken (bounded).
    task automatic send(input logic [DATA_W-1:0] code, input int budget, input string tag);
        bit rdy;
        bit done;
        done      = 1'b0;
        din       = code;
        din_valid = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            rdy = din_ready;
            step(1);
            if (rdy) done = 1'b1;
        end
        chk({tag, "_accepted"}, 32'(done), 32'd1);
    endtask

    // Frame monitor: counts ones and enabled clocks, checks at each tick.
    always begin
        bit   e_at;
        bit   r_at;
        exp_t e;
        @(posedge clk);
        e_at = (ena === 1'b1);
        r_at = (rst_n === 1'b1);
        #1;
        if (!r_at || rst_n !== 1'b1) begin
            mon_ones = 0;
            mon_len  = 0;
        end else begin
            chk("underrun_without_tick", 32'(underrun & ~sample_tick), 32'd0);
            if (e_at) begin
                mon_len++;
                if (pdm_out === 1'b1) mon_ones++;
                if (sample_tick === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_tick", 32'(sample_tick), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_ones", 32'(mon_ones), 32'(e.ones));
                        chk("frame_underrun", 32'(underrun), 32'(e.urun));
                        chk("frame_len", 32'(mon_len), 32'(FRAME));
                    end
                    mon_ones = 0;
                    mon_len  = 0;
                end
            end else begin
                chk("tick_while_disabled", 32'(sample_tick), 32'd0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        step(3);

        // Reset values
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        chk("rst_pdm_out", 32'(pdm_out), 32'd0);
        chk("rst_sample_tick", 32'(sample_tick), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Midscale default: 0,1,0,1 and 128 ones per frame
        push(128, 1);
        push(128, 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("midscale_pattern", 32'(pdm_out), 32'(i % 2));
        end

        // Load 0x40 mid-frame 2
        to_pos(FRAME + 50);
        chk("ready_idle", 32'(din_ready), 32'd1);
        din       = 8'h40;
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        chk("ready_low_after_load", 32'(din_ready), 32'd0);
        to_pos(2 * FRAME - 1);
        chk("ready_low_before_boundary", 32'(din_ready), 32'd0);
        step(1);
        chk("ready_high_after_boundary", 32'(din_ready), 32'd1);
        chk("tick_at_boundary", 32'(sample_tick), 32'd1);
        chk("no_underrun_when_loaded", 32'(underrun), 32'd0);
        push(64, 0);

        // 0x00 then 0xFF with din_valid held through backpressure
        to_pos(2 * FRAME + 88);
        din       = 8'h00;
        din_valid = 1'b1;
        step(1);
        din = 8'hFF;
        chk("first_code_taken", 32'(din_ready), 32'd0);
        to_pos(3 * FRAME - 1);
        chk("second_code_held_off", 32'(din_ready), 32'd0);
        step(1);
        chk("ready_after_first_boundary", 32'(din_ready), 32'd1);
        step(1);
        chk("second_code_taken", 32'(din_ready), 32'd0);
        din_valid = 1'b0;
        push(0, 0);
        push(255, 0);
        push(16, 0);
        push(32, 0);
        push(48, 0);

        // Streaming with din_valid held: one transfer per frame
        to_pos(4 * FRAME + 10);
        send(8'h10, 4, "stream_0x10");
        chk("stream_0x10_pos", 32'(pos), 32'(4 * FRAME + 11));
        send(8'h20, 300, "stream_0x20");
        chk("stream_0x20_pos", 32'(pos), 32'(5 * FRAME + 1));
        send(8'h30, 300, "stream_0x30");
        chk("stream_0x30_pos", 32'(pos), 32'(6 * FRAME + 1));
        din_valid = 1'b0;

        // Midscale code for the ena-freeze frame
        to_pos(7 * FRAME + 8);
        send(8'h80, 4, "load_0x80");
        din_valid = 1'b0;
        push(128, 0);

        // ena low for 37 clocks at frame offset 100 (pdm=1), load 0x50 meanwhile
        to_pos(8 * FRAME + 100);
        chk("pdm_before_freeze", 32'(pdm_out), 32'd1);
        ena = 1'b0;
        for (int i = 0; i < 37; i++) begin
            if (i == 5) begin
                din       = 8'h50;
                din_valid = 1'b1;
            end
            step(1);
            if (i == 5) begin
                din_valid = 1'b0;
                chk("xfer_while_disabled", 32'(din_ready), 32'd0);
            end
            chk("pdm_frozen", 32'(pdm_out), 32'd1);
            chk("no_tick_frozen", 32'(sample_tick), 32'd0);
        end
        chk("pos_frozen", 32'(pos), 32'(8 * FRAME + 100));
        ena = 1'b1;
        step(1);
        chk("pdm_resume_0", 32'(pdm_out), 32'd0);
        step(1);
        chk("pdm_resume_1", 32'(pdm_out), 32'd1);
        push(80, 0);

        // Reset at os_cnt=100 with a code pending
        to_pos(9 * FRAME + 20);
        send(8'h20, 4, "load_discarded");
        din_valid = 1'b0;
        to_pos(9 * FRAME + 100);
        chk("pending_before_reset", 32'(din_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_din_ready", 32'(din_ready), 32'd1);
        chk("async_rst_pdm_out", 32'(pdm_out), 32'd0);
        chk("async_rst_sample_tick", 32'(sample_tick), 32'd0);
        chk("async_rst_underrun", 32'(underrun), 32'd0);
        sb.delete();
        step(2);
        pos = 0;
        push(128, 1);
        push(128, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("post_reset_pattern", 32'(pdm_out), 32'(i % 2));
        end
        to_pos(2 * FRAME);
        chk("all_frames_seen", 32'(sb.size()), 32'd0);

        ena = 1'b0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
